// File: rtl/oisc8_ram_arbiter.sv
// oisc8_ram_arbiter: shares the single OISC8 RAM port between the CPU memory
// block and a DMA-style requester. The CPU normally wins. A starvation counter
// forces a bounded DMA burst during which the CPU is stalled. Read ownership is
// tracked so that the 1-cycle-latency read data is flagged to the right side.
module oisc8_ram_arbiter #(
  parameter int AWIDTH    = 24,
  parameter int DWIDTH    = 16,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd_en,
  input  logic              cpu_wr_en,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wr_data,
  output logic [DWIDTH-1:0] cpu_rd_data,
  output logic              cpu_rd_valid,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [AWIDTH-1:0] dma_addr,
  input  logic [DWIDTH-1:0] dma_wr_data,
  output logic              dma_gnt,
  output logic [DWIDTH-1:0] dma_rd_data,
  output logic              dma_rd_valid,
  output logic              ram_rd_en,
  output logic              ram_wr_en,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_wr_data,
  input  logic [DWIDTH-1:0] ram_rd_data
);

  // state | meaning
  // S_CPU | CPU has fixed priority; DMA served only when CPU is idle
  // S_DMA | forced DMA burst; CPU stalled while DMA keeps requesting
  typedef enum logic {S_CPU, S_DMA} state_t;

  localparam logic [7:0] MAX_WAIT_C  = 8'(MAX_WAIT);
  localparam logic [7:0] BURST_LEN_C = 8'(BURST_LEN);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       rd_owner_cpu_q, rd_owner_cpu_d;
  logic       rd_owner_dma_q, rd_owner_dma_d;

  logic cpu_act;
  logic cpu_serve;
  logic dma_serve;

  assign cpu_act = cpu_rd_en | cpu_wr_en;

  // State, counters and read-ownership registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_CPU;
      wait_cnt_q     <= 8'd0;
      burst_cnt_q    <= 8'd0;
      rd_owner_cpu_q <= 1'b0;
      rd_owner_dma_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      burst_cnt_q    <= burst_cnt_d;
      rd_owner_cpu_q <= rd_owner_cpu_d;
      rd_owner_dma_q <= rd_owner_dma_d;
    end
  end

  // Arbitration: who is served this cycle and how the counters move
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;
    cpu_serve   = 1'b0;
    dma_serve   = 1'b0;
    case (state_q)
      S_CPU: begin
        if (cpu_act) begin
          cpu_serve = 1'b1;
        end else if (dma_req) begin
          dma_serve = 1'b1;
        end
        if (dma_req && cpu_act) begin
          if (wait_cnt_q + 8'd1 == MAX_WAIT_C) begin
            state_d     = S_DMA;
            wait_cnt_d  = 8'd0;
            burst_cnt_d = 8'd0;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else if (dma_serve) begin
          wait_cnt_d = 8'd0;
        end
      end
      S_DMA: begin
        wait_cnt_d = 8'd0;
        if (dma_req) begin
          dma_serve = 1'b1;
          if (burst_cnt_q + 8'd1 == BURST_LEN_C) begin
            state_d     = S_CPU;
            burst_cnt_d = 8'd0;
          end else begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end
        end else begin
          // DMA let go early: hand the port back to the CPU this same cycle
          cpu_serve   = cpu_act;
          state_d     = S_CPU;
          burst_cnt_d = 8'd0;
        end
      end
      default: state_d = S_CPU;
    endcase
    rd_owner_cpu_d = cpu_serve & cpu_rd_en;
    rd_owner_dma_d = dma_serve & ~dma_we;
  end

  // RAM-side mux and requester-side outputs, all forced low during reset
  always_comb begin
    ram_rd_en    = 1'b0;
    ram_wr_en    = 1'b0;
    ram_addr     = '0;
    ram_wr_data  = '0;
    cpu_stall    = 1'b0;
    dma_gnt      = 1'b0;
    cpu_rd_valid = 1'b0;
    dma_rd_valid = 1'b0;
    cpu_rd_data  = '0;
    dma_rd_data  = '0;
    if (!rst) begin
      if (cpu_serve) begin
        ram_rd_en   = cpu_rd_en;
        ram_wr_en   = cpu_wr_en;
        ram_addr    = cpu_addr;
        ram_wr_data = cpu_wr_data;
      end else if (dma_serve) begin
        ram_rd_en   = ~dma_we;
        ram_wr_en   = dma_we;
        ram_addr    = dma_addr;
        ram_wr_data = dma_wr_data;
      end
      cpu_stall    = cpu_act & ~cpu_serve;
      dma_gnt      = dma_serve;
      cpu_rd_valid = rd_owner_cpu_q;
      dma_rd_valid = rd_owner_dma_q;
      cpu_rd_data  = ram_rd_data;
      dma_rd_data  = ram_rd_data;
    end
  end

endmodule

// File: tb/tb_oisc8_ram_arbiter.sv
// Directed bench for oisc8_ram_arbiter with a tiny 1-cycle-latency RAM model.
module tb_oisc8_ram_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_rd_en, cpu_wr_en;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wr_data;
  logic [DW-1:0] cpu_rd_data;
  logic          cpu_rd_valid, cpu_stall;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wr_data;
  logic          dma_gnt;
  logic [DW-1:0] dma_rd_data;
  logic          dma_rd_valid;
  logic          ram_rd_en, ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic [DW-1:0] ram_rd_data = '0;

  int checks   = 0;
  int failures = 0;

  oisc8_ram_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_WAIT(4), .BURST_LEN(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
    .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
    .cpu_rd_valid(cpu_rd_valid), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wr_data(dma_wr_data), .dma_gnt(dma_gnt), .dma_rd_data(dma_rd_data),
    .dma_rd_valid(dma_rd_valid),
    .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  // RAM model: address 0x10 holds BEEF, everything else reads addr[15:0]^5A5A
  always @(posedge clk) begin
    if (ram_rd_en)
      ram_rd_data <= (ram_addr == 24'h000010) ? 16'hBEEF : (ram_addr[15:0] ^ 16'h5A5A);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Move to 1ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    cpu_rd_en = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 24'h000010; cpu_wr_data = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wr_data = '0;
    #2;
    chk("rst_ram_rd_en", ram_rd_en, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_cpu_stall", cpu_stall, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_rd_en = 1'b0; cpu_addr = '0;
    #1;
    chk("idle_ram_rd_en", ram_rd_en, 0);
    chk("idle_ram_wr_en", ram_wr_en, 0);
    chk("idle_ram_addr", ram_addr, 0);
    chk("idle_dma_gnt", dma_gnt, 0);
    chk("idle_cpu_rd_valid", cpu_rd_valid, 0);
    chk("idle_dma_rd_valid", dma_rd_valid, 0);

    // CPU read of 0x10
    tick();
    cpu_rd_en = 1'b1; cpu_addr = 24'h000010;
    #1;
    chk("cpu_rd_ram_rd_en", ram_rd_en, 1);
    chk("cpu_rd_ram_addr", ram_addr, 32'h000010);
    chk("cpu_rd_stall", cpu_stall, 0);
    tick();
    cpu_rd_en = 1'b0;
    #1;
    chk("cpu_rd_valid", cpu_rd_valid, 1);
    chk("cpu_rd_data", cpu_rd_data, 32'hBEEF);
    chk("cpu_rd_dma_valid", dma_rd_valid, 0);

    // CPU write passes through
    cpu_wr_en = 1'b1; cpu_addr = 24'h000222; cpu_wr_data = 16'hCAFE;
    #1;
    chk("cpu_wr_ram_wr_en", ram_wr_en, 1);
    chk("cpu_wr_ram_data", ram_wr_data, 32'hCAFE);
    tick();
    cpu_wr_en = 1'b0;
    #1;
    chk("cpu_wr_no_valid", cpu_rd_valid, 0);

    // Uncontended DMA write
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 24'hFF0100; dma_wr_data = 16'h1234;
    #1;
    chk("dma_wr_gnt", dma_gnt, 1);
    chk("dma_wr_ram_wr_en", ram_wr_en, 1);
    chk("dma_wr_ram_rd_en", ram_rd_en, 0);
    chk("dma_wr_ram_addr", ram_addr, 32'hFF0100);
    chk("dma_wr_ram_data", ram_wr_data, 32'h1234);
    tick();
    dma_req = 1'b0;
    #1;
    chk("dma_wr_no_valid", dma_rd_valid, 0);

    // Starvation: CPU reads 0x20 every cycle, DMA reads 0x30 continuously
    cpu_rd_en = 1'b1; cpu_addr = 24'h000020;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 24'h000030;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("starve_lose_gnt", dma_gnt, 0);
      chk("starve_lose_stall", cpu_stall, 0);
      chk("starve_lose_addr", ram_addr, 32'h000020);
      tick();
    end
    for (int j = 0; j < 8; j++) begin
      #1;
      chk("burst_gnt", dma_gnt, 1);
      chk("burst_stall", cpu_stall, 1);
      chk("burst_addr", ram_addr, 32'h000030);
      chk("burst_cpu_valid", cpu_rd_valid, (j == 0) ? 1 : 0);
      chk("burst_dma_valid", dma_rd_valid, (j == 0) ? 0 : 1);
      if (j > 0) chk("burst_dma_data", dma_rd_data, 32'h5A6A);
      tick();
    end
    #1;
    chk("post_burst_gnt", dma_gnt, 0);
    chk("post_burst_stall", cpu_stall, 0);
    chk("post_burst_addr", ram_addr, 32'h000020);
    chk("post_burst_dma_valid", dma_rd_valid, 1);
    chk("post_burst_cpu_valid", cpu_rd_valid, 0);
    tick();
    // One uncontended DMA grant clears the partial wait count
    cpu_rd_en = 1'b0;
    #1;
    chk("clear_gnt", dma_gnt, 1);
    tick();

    // Early burst exit after 3 grants
    cpu_rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("early_lose_gnt", dma_gnt, 0);
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("early_burst_gnt", dma_gnt, 1);
      chk("early_burst_stall", cpu_stall, 1);
      tick();
    end
    dma_req = 1'b0;
    #1;
    chk("early_exit_stall", cpu_stall, 0);
    chk("early_exit_gnt", dma_gnt, 0);
    chk("early_exit_rd_en", ram_rd_en, 1);
    chk("early_exit_addr", ram_addr, 32'h000020);
    tick();
    // Back in S_CPU with a cleared wait count: DMA loses exactly 4 more cycles
    dma_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rewait_lose_gnt", dma_gnt, 0);
      tick();
    end
    #1;
    chk("rewait_gnt", dma_gnt, 1);
    chk("rewait_stall", cpu_stall, 1);
    tick();
    dma_req = 1'b0; cpu_rd_en = 1'b0;
    tick();

    // Back-to-back ownership switch
    cpu_rd_en = 1'b1; cpu_addr = 24'h000040;
    tick();
    cpu_rd_en = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 24'h000050;
    #1;
    chk("b2b_dma_gnt", dma_gnt, 1);
    chk("b2b_cpu_valid", cpu_rd_valid, 1);
    chk("b2b_dma_valid0", dma_rd_valid, 0);
    chk("b2b_cpu_data", cpu_rd_data, 32'h5A1A);
    tick();
    dma_req = 1'b0;
    #1;
    chk("b2b_cpu_valid1", cpu_rd_valid, 0);
    chk("b2b_dma_valid1", dma_rd_valid, 1);
    chk("b2b_dma_data", dma_rd_data, 32'h5A0A);
    tick();
    chk("b2b_cpu_valid2", cpu_rd_valid, 0);
    chk("b2b_dma_valid2", dma_rd_valid, 0);

    // Reset asserted while a read is being issued drops it
    cpu_rd_en = 1'b1; cpu_addr = 24'h000010;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_ram_rd_en", ram_rd_en, 0);
    chk("midrst_stall", cpu_stall, 0);
    tick();
    chk("midrst_cpu_valid", cpu_rd_valid, 0);
    rst = 1'b0;
    tick();
    cpu_rd_en = 1'b0;
    #1;
    chk("pre_async_valid", cpu_rd_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", cpu_rd_valid, 0);
    chk("async_rst_data", cpu_rd_data, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("after_rst_valid", cpu_rd_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oisc8_ram_arbiter.md
Name: oisc8_ram_arbiter

Overview:
Shares the single OISC8 RAM port between the CPU data path (memory-pointer/stack accesses from the memory block) and a secondary DMA-style requester (e.g. a com/loader engine).
- CPU has fixed priority; a starvation counter forces DMA bursts when DMA has waited too long. The CPU is stalled during those bursts.
- Tracks ownership of each in-flight read so the 1-cycle-latency RAM read data returns to the correct requester.
- Sits between the memory block and the processor RAM port.

Parameters:
AWIDTH, 24, RAM address width
DWIDTH, 16, RAM data width
MAX_WAIT, 4, contended cycles DMA may lose before a forced DMA burst (legal range 1..255)
BURST_LEN, 8, maximum consecutive DMA grants in a forced burst (legal range 1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cpu_rd_en  in  1  CPU read request this cycle
cpu_wr_en  in  1  CPU write request this cycle
cpu_addr  in  AWIDTH  CPU address
cpu_wr_data  in  DWIDTH  CPU write data
cpu_rd_data  out  DWIDTH  read data to CPU (wired from ram_rd_data)
cpu_rd_valid  out  1  cpu_rd_data carries the CPU read issued last cycle
cpu_stall  out  1  CPU request not served this cycle; CPU holds request
dma_req  in  1  DMA access request; held with addr/data until granted
dma_we  in  1  1 = write, 0 = read (qualified by dma_req)
dma_addr  in  AWIDTH  DMA address
dma_wr_data  in  DWIDTH  DMA write data
dma_gnt  out  1  DMA access accepted this cycle
dma_rd_data  out  DWIDTH  read data to DMA (wired from ram_rd_data)
dma_rd_valid  out  1  dma_rd_data carries the DMA read granted last cycle
ram_rd_en  out  1  RAM read enable
ram_wr_en  out  1  RAM write enable
ram_addr  out  AWIDTH  RAM address
ram_wr_data  out  DWIDTH  RAM write data
ram_rd_data  in  DWIDTH  RAM read data, valid 1 cycle after ram_rd_en

Behaviour:
- Definitions: cpu_act = cpu_rd_en|cpu_wr_en. RAM-side outputs are combinational muxes of the owning requester. Ownership is decided by registered state plus current requests.
- States: S_CPU (reset state) and S_DMA. Registers: wait_cnt (8b), burst_cnt (8b), rd_owner_cpu, rd_owner_dma.
- S_CPU:
  - If cpu_act: CPU is served. cpu_stall=0, dma_gnt=0.
  - Else if dma_req: DMA is served the same cycle (dma_gnt=1).
  - If dma_req & cpu_act: wait_cnt+1. When wait_cnt reaches MAX_WAIT, go to S_DMA next cycle, with burst_cnt=0 and wait_cnt=0.
  - A DMA grant with no contention clears wait_cnt.
- S_DMA:
  - If dma_req: DMA is served, dma_gnt=1, burst_cnt+1. cpu_stall=cpu_act.
  - Return to S_CPU when dma_req=0 (in that cycle CPU is served, no stall) or after the BURST_LEN-th grant. wait_cnt stays 0.
- Served requester drives RAM:
  - ram_rd_en / ram_wr_en = its rd/wr enables; CPU may assert both (passed through).
  - DMA: ram_rd_en=~dma_we, ram_wr_en=dma_we.
  - Nobody served: ram_rd_en=ram_wr_en=0, ram_addr=0, ram_wr_data=0.
- Read return:
  - rd_owner_cpu <= served CPU read; rd_owner_dma <= served DMA read.
  - cpu_rd_valid=rd_owner_cpu, dma_rd_valid=rd_owner_dma; at most one is 1.
  - A stalled request never produces rd_valid.
- Latency: uncontended access has 0-cycle grant and 1-cycle read data. Worst-case CPU stall is BURST_LEN cycles. Worst-case DMA wait is MAX_WAIT+1 cycles.
- Reset (async, any time): state=S_CPU, counters=0, rd_owner_*=0. All outputs 0 while rst=1; an in-flight read is dropped (no valid after reset).

Test Plan:
- Reset idle: rst=1 then release, no requests -> all outputs 0, state S_CPU; assert rst mid-read -> next cycle cpu_rd_valid=0.
- CPU read: cpu_rd_en=1, cpu_addr=24'h000010, RAM returns 16'hBEEF -> ram_rd_en=1, ram_addr=24'h000010 same cycle; next cycle cpu_rd_valid=1, cpu_rd_data=16'hBEEF, dma_rd_valid=0.
- Uncontended DMA write: dma_req=1, dma_we=1, dma_addr=24'hFF0100, dma_wr_data=16'h1234, cpu idle -> dma_gnt=1, ram_wr_en=1 with matching addr/data same cycle.
- Starvation: MAX_WAIT=4, BURST_LEN=8, CPU reads every cycle, DMA reads continuously -> dma_gnt=0 for 4 cycles, then 8 consecutive dma_gnt=1 with cpu_stall=1 and dma_rd_valid trailing each by 1, then CPU resumes, cpu_stall=0.
- Early burst exit: in S_DMA after 3 grants drop dma_req -> same cycle CPU served (cpu_stall=0), state returns to S_CPU, wait_cnt=0.
- Back-to-back ownership switch: CPU read cycle N, DMA read cycle N+1 -> cpu_rd_valid=1 only at N+1, dma_rd_valid=1 only at N+2, never both high.
